// File: rtl/fifo_wr_feeder.sv
// Write-side producer for the async FIFO: 2-entry skid buffer feeding winc/wdata,
// plus Gray-pointer fill level decode. Optional statistics: FIFO_WR_FEEDER_STATS_EN.
module fifo_wr_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PTR_WIDTH  = 4,
    parameter int AFULL_LVL  = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  wfull,
    input  logic [PTR_WIDTH-1:0]  wptr,
    input  logic [PTR_WIDTH-1:0]  wq2_rptr,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [PTR_WIDTH-1:0]  wlevel,
    output logic                  walmost_full,
    output logic                  werr,
    output logic [15:0]           wstat_writes,
    output logic [15:0]           wstat_stalls,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a word transfers on any wclk edge where s_valid and s_ready are both high;
    // s_valid may not be withdrawn by the source until that edge, s_ready depends only on state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [PTR_WIDTH:0] DEPTH = PTR_WIDTH'(1) << ADDR_WIDTH;
    localparam logic [PTR_WIDTH:0] AFULL = AFULL_LVL[PTR_WIDTH:0];

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head, w_head_nxt;
    logic [DATA_WIDTH-1:0] r_tail, w_tail_nxt;
    logic                  w_accept;
    logic [PTR_WIDTH-1:0]  w_wbin, w_rbin, w_level;
    logic [PTR_WIDTH-1:0]  r_level;
    logic                  r_afull, r_err;

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign s_ready     = (r_state != ST_FULL);
    assign winc        = (r_state != ST_EMPTY) & ~wfull;
    assign w_accept    = s_valid & s_ready;
    assign wdata       = r_head;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = s_data;
                end
            end
            ST_ONE: begin
                if (w_accept && !winc) begin
                    w_state_nxt = ST_FULL;
                    w_tail_nxt  = s_data;
                end else if (!w_accept && winc) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && winc) begin
                    w_head_nxt  = s_data;
                end
            end
            ST_FULL: begin
                if (winc) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Modulo subtraction absorbs pointer wrap without a special case.
    assign w_wbin  = gray2bin(wptr);
    assign w_rbin  = gray2bin(wq2_rptr);
    assign w_level = w_wbin - w_rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_level <= '0;
            r_afull <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_level <= w_level;
            r_afull <= ({1'b0, w_level} >= AFULL);
            r_err   <= r_err | ({1'b0, w_level} > DEPTH);
        end
    end

    assign wlevel       = r_level;
    assign walmost_full = r_afull;
    assign werr         = r_err;

`ifdef FIFO_WR_FEEDER_STATS_EN
    logic [15:0] r_stat_writes, r_stat_stalls;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_stat_writes <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (winc && r_stat_writes != 16'hFFFF)
                r_stat_writes <= r_stat_writes + 16'd1;
            if ((r_state != ST_EMPTY) && wfull && r_stat_stalls != 16'hFFFF)
                r_stat_stalls <= r_stat_stalls + 16'd1;
        end
    end

    assign wstat_writes = r_stat_writes;
    assign wstat_stalls = r_stat_stalls;
`else
    assign wstat_writes = 16'd0;
    assign wstat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// Bench for fifo_wr_feeder: scoreboard on the write stream, table of pointer vectors.
module tb_fifo_wr_feeder;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        wfull = 1'b0;
    logic [3:0]  wptr = '0;
    logic [3:0]  wq2_rptr = '0;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  wlevel;
    logic        walmost_full;
    logic        werr;
    logic [15:0] wstat_writes;
    logic [15:0] wstat_stalls;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;

    logic [7:0] exp_q[$];
    int         wr_cyc[$];
    int         acc_cyc[$];
    logic [7:0] exp_word;

    typedef struct {
        logic [3:0] wp;
        logic [3:0] rp;
        logic [3:0] lvl;
        logic       af;
        logic       err;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] prev_lvl;

    fifo_wr_feeder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .PTR_WIDTH(4), .AFULL_LVL(6)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
        .winc(winc), .wdata(wdata), .wlevel(wlevel), .walmost_full(walmost_full),
        .werr(werr), .wstat_writes(wstat_writes), .wstat_stalls(wstat_stalls),
        .o_dbg_state(o_dbg_state)
    );

    // clock / cycle counter
    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor: mid-cycle sampling, pop on write before push on accept
    always @(negedge wclk) begin
        if (wrst_n) begin
            check("winc_model", winc, (exp_q.size() != 0) && !wfull);
            check("s_ready_model", s_ready, exp_q.size() < 2);
            if (winc) begin
                if (exp_q.size() == 0) begin
                    check("write_with_empty_queue", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("wdata", wdata, exp_word);
                end
                wr_cyc.push_back(cyc);
                n_wr++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        @(posedge wclk); #1;
        wrst_n = 1'b0;
        s_valid = 1'b0;
        wfull = 1'b0;
        exp_q.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        n_wr = 0;
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        bit done;
        int t;
        done = 0;
        t = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!done) begin
            @(negedge wclk);
            if (s_ready) done = 1;
            @(posedge wclk); #1;
            t++;
            if (!done && t > 50) begin
                check("send_timeout", 1, 0);
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge wclk); #1;
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{4'b0000, 4'b0000, 4'd0,  1'b0, 1'b0};
        vecs[1] = '{4'b1001, 4'b1100, 4'd6,  1'b1, 1'b0};
        vecs[2] = '{4'b0011, 4'b1001, 4'd4,  1'b0, 1'b0};
        vecs[3] = '{4'b1100, 4'b0000, 4'd8,  1'b1, 1'b0};
        vecs[4] = '{4'b0111, 4'b0000, 4'd5,  1'b0, 1'b0};
        vecs[5] = '{4'b1110, 4'b0000, 4'd11, 1'b1, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 4'd0,  1'b0, 1'b1};
        vecs[7] = '{4'b1001, 4'b1100, 4'd6,  1'b1, 1'b1};

        // reset values
        do_reset();
        @(negedge wclk);
        check("rst_s_ready", s_ready, 1);
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wlevel", wlevel, 0);
        check("rst_walmost_full", walmost_full, 0);
        check("rst_werr", werr, 0);
        check("rst_stat_writes", wstat_writes, 0);
        check("rst_stat_stalls", wstat_stalls, 0);
        check("rst_state", o_dbg_state, 0);

        // back-to-back stream, no back-pressure
        @(posedge wclk); #1;
        for (int i = 1; i <= 10; i++) send(8'(i));
        s_valid = 1'b0;
        drain();
        check("stream_write_count", wr_cyc.size(), 10);
        if (acc_cyc.size() != 0 && wr_cyc.size() == 10) begin
            for (int i = 0; i < 10; i++)
                check("stream_write_cycle", wr_cyc[i], acc_cyc[0] + 1 + i);
        end

        // wfull held 5 cycles mid-burst
        do_reset();
        @(posedge wclk); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'h21 + 8'(i));
                s_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge wclk);
                #1 wfull = 1'b1;
                repeat (5) @(posedge wclk);
                #1 wfull = 1'b0;
            end
        join
        drain();
        check("stall_write_count", n_wr, 8);
`ifdef FIFO_WR_FEEDER_STATS_EN
        check("stat_stalls", wstat_stalls, 5);
        check("stat_writes", wstat_writes, 8);
`else
        check("stat_stalls_off", wstat_stalls, 0);
        check("stat_writes_off", wstat_writes, 0);
`endif

        // pointer decode table; werr must stick once set
        prev_lvl = wlevel;
        for (int i = 0; i < 8; i++) begin
            @(posedge wclk); #1;
            wptr = vecs[i].wp;
            wq2_rptr = vecs[i].rp;
            @(negedge wclk);
            check("wlevel_lag", wlevel, prev_lvl);
            @(posedge wclk); #1;
            check("wlevel", wlevel, vecs[i].lvl);
            check("walmost_full", walmost_full, vecs[i].af);
            check("werr", werr, vecs[i].err);
            prev_lvl = vecs[i].lvl;
        end

        // werr clears only on reset
        do_reset();
        @(negedge wclk);
        check("werr_after_reset", werr, 0);
        @(posedge wclk); #1;
        check("wlevel_after_reset", wlevel, 6);
        check("werr_legal_after_reset", werr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
